// File: rtl/axi4lite_pkg.sv
// Shared AXI4-Lite definitions: response codes and the channel state
// encodings used by the register responder.
package axi4lite_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {
      W_IDLE,
      W_HAVE_AW,
      W_HAVE_W,
      W_RESP
   } wr_state_t;

   typedef enum logic {
      R_IDLE,
      R_RESP
   } rd_state_t;

endpackage

// File: rtl/axi4lite_reg_responder.sv
// AXI4-Lite responder holding NUM_REGS 32-bit read/write control registers.
//
// Ports:
//   clock, reset           : single clock, synchronous active-high reset
//   s_axi_aw*/w*/b*        : write address, write data, write response channels
//   s_axi_ar*/r*           : read address and read data channels
//   regs_o                 : register contents, register n at [32n+31:32n]
//   wr_pulse_o             : one-cycle pulse when register n is updated
//
// One write is outstanding at a time; AW and W may arrive in either order.
// Reads and writes run on fully independent state machines.
module axi4lite_reg_responder
   import axi4lite_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 6,
   parameter int NUM_REGS   = 4
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic [ADDR_WIDTH-1:0]          s_axi_awaddr,
   input  logic [2:0]                     s_axi_awprot,
   input  logic                           s_axi_awvalid,
   output logic                           s_axi_awready,
   input  logic [DATA_WIDTH-1:0]          s_axi_wdata,
   input  logic [DATA_WIDTH/8-1:0]        s_axi_wstrb,
   input  logic                           s_axi_wvalid,
   output logic                           s_axi_wready,
   output logic [1:0]                     s_axi_bresp,
   output logic                           s_axi_bvalid,
   input  logic                           s_axi_bready,
   input  logic [ADDR_WIDTH-1:0]          s_axi_araddr,
   input  logic [2:0]                     s_axi_arprot,
   input  logic                           s_axi_arvalid,
   output logic                           s_axi_arready,
   output logic [DATA_WIDTH-1:0]          s_axi_rdata,
   output logic [1:0]                     s_axi_rresp,
   output logic                           s_axi_rvalid,
   input  logic                           s_axi_rready,
   output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o,
   output logic [NUM_REGS-1:0]            wr_pulse_o
);

   localparam int IDX_W = ADDR_WIDTH - 2;

   wr_state_t wr_state;
   rd_state_t rd_state;

   logic [DATA_WIDTH-1:0]   regs [NUM_REGS];
   logic [IDX_W-1:0]        aw_idx_q;
   logic [DATA_WIDTH-1:0]   w_data_q;
   logic [DATA_WIDTH/8-1:0] w_strb_q;

   logic                    aw_hs, w_hs, ar_hs;
   logic                    commit, commit_hit;
   logic [IDX_W-1:0]        commit_idx;
   logic [DATA_WIDTH-1:0]   commit_data;
   logic [DATA_WIDTH/8-1:0] commit_strb;
   logic [IDX_W-1:0]        rd_idx;
   logic                    rd_hit;
   logic [DATA_WIDTH-1:0]   rd_val;
   logic                    unused_ok;

   assign unused_ok = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr[1:0], s_axi_araddr[1:0]};

   function automatic logic [DATA_WIDTH-1:0] merge_bytes(
      input logic [DATA_WIDTH-1:0]   old_val,
      input logic [DATA_WIDTH-1:0]   new_val,
      input logic [DATA_WIDTH/8-1:0] strb
   );
      logic [DATA_WIDTH-1:0] m;
      m = old_val;
      for (int unsigned b = 0; b < DATA_WIDTH/8; b++) begin
         if (strb[b]) m[8*b +: 8] = new_val[8*b +: 8];
      end
      return m;
   endfunction

   // Readies are a decode of the state, gated by reset so they read low
   // for every cycle reset is held and high straight after it is released.
   assign s_axi_awready = !reset && (wr_state == W_IDLE || wr_state == W_HAVE_W);
   assign s_axi_wready  = !reset && (wr_state == W_IDLE || wr_state == W_HAVE_AW);
   assign s_axi_arready = !reset && (rd_state == R_IDLE);

   assign aw_hs = s_axi_awvalid && s_axi_awready;
   assign w_hs  = s_axi_wvalid  && s_axi_wready;
   assign ar_hs = s_axi_arvalid && s_axi_arready;

   // The write completes on the edge where the second half arrives, so the
   // missing half comes straight from the bus and the other from the latch.
   always_comb begin
      commit      = 1'b0;
      commit_idx  = aw_idx_q;
      commit_data = w_data_q;
      commit_strb = w_strb_q;
      case (wr_state)
         W_IDLE: if (aw_hs && w_hs) begin
            commit      = 1'b1;
            commit_idx  = s_axi_awaddr[ADDR_WIDTH-1:2];
            commit_data = s_axi_wdata;
            commit_strb = s_axi_wstrb;
         end
         W_HAVE_AW: if (w_hs) begin
            commit      = 1'b1;
            commit_data = s_axi_wdata;
            commit_strb = s_axi_wstrb;
         end
         W_HAVE_W: if (aw_hs) begin
            commit      = 1'b1;
            commit_idx  = s_axi_awaddr[ADDR_WIDTH-1:2];
         end
         default: ;
      endcase
      commit_hit = 32'(commit_idx) < NUM_REGS;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_state     <= W_IDLE;
         aw_idx_q     <= '0;
         w_data_q     <= '0;
         w_strb_q     <= '0;
         s_axi_bvalid <= 1'b0;
         s_axi_bresp  <= RESP_OKAY;
         wr_pulse_o   <= '0;
         for (int unsigned n = 0; n < NUM_REGS; n++) regs[n] <= '0;
      end else begin
         wr_pulse_o <= '0;
         if (commit) begin
            wr_state     <= W_RESP;
            s_axi_bvalid <= 1'b1;
            s_axi_bresp  <= commit_hit ? RESP_OKAY : RESP_SLVERR;
            for (int unsigned n = 0; n < NUM_REGS; n++) begin
               if (32'(commit_idx) == n) begin
                  regs[n]       <= merge_bytes(regs[n], commit_data, commit_strb);
                  wr_pulse_o[n] <= 1'b1;
               end
            end
         end else begin
            case (wr_state)
               W_IDLE: begin
                  if (aw_hs) begin
                     aw_idx_q <= s_axi_awaddr[ADDR_WIDTH-1:2];
                     wr_state <= W_HAVE_AW;
                  end else if (w_hs) begin
                     w_data_q <= s_axi_wdata;
                     w_strb_q <= s_axi_wstrb;
                     wr_state <= W_HAVE_W;
                  end
               end
               W_RESP: if (s_axi_bready) begin
                  s_axi_bvalid <= 1'b0;
                  wr_state     <= W_IDLE;
               end
               default: ;
            endcase
         end
      end
   end

   assign rd_idx = s_axi_araddr[ADDR_WIDTH-1:2];
   assign rd_hit = 32'(rd_idx) < NUM_REGS;

   always_comb begin
      rd_val = '0;
      for (int unsigned n = 0; n < NUM_REGS; n++) begin
         if (32'(rd_idx) == n) rd_val = regs[n];
      end
   end

   // rd_val samples the pre-edge register value, so a read accepted on the
   // same edge as a write update returns the old contents.
   always_ff @(posedge clock) begin
      if (reset) begin
         rd_state     <= R_IDLE;
         s_axi_rvalid <= 1'b0;
         s_axi_rdata  <= '0;
         s_axi_rresp  <= RESP_OKAY;
      end else begin
         case (rd_state)
            R_IDLE: if (ar_hs) begin
               s_axi_rdata  <= rd_hit ? rd_val : '0;
               s_axi_rresp  <= rd_hit ? RESP_OKAY : RESP_SLVERR;
               s_axi_rvalid <= 1'b1;
               rd_state     <= R_RESP;
            end
            R_RESP: if (s_axi_rready) begin
               s_axi_rvalid <= 1'b0;
               rd_state     <= R_IDLE;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      regs_o = '0;
      for (int unsigned n = 0; n < NUM_REGS; n++) regs_o[DATA_WIDTH*n +: DATA_WIDTH] = regs[n];
   end

endmodule

// File: tb/tb_axi4lite_reg_responder.sv
// Self-checking bench for axi4lite_reg_responder: directed scenarios plus a
// randomized phase, all checked against a register-array reference model.
module tb_axi4lite_reg_responder;

   logic         clock = 1'b0;
   logic         reset;
   logic [5:0]   s_axi_awaddr, s_axi_araddr;
   logic [2:0]   s_axi_awprot, s_axi_arprot;
   logic         s_axi_awvalid, s_axi_awready;
   logic [31:0]  s_axi_wdata;
   logic [3:0]   s_axi_wstrb;
   logic         s_axi_wvalid, s_axi_wready;
   logic [1:0]   s_axi_bresp;
   logic         s_axi_bvalid, s_axi_bready;
   logic         s_axi_arvalid, s_axi_arready;
   logic [31:0]  s_axi_rdata;
   logic [1:0]   s_axi_rresp;
   logic         s_axi_rvalid, s_axi_rready;
   logic [127:0] regs_o;
   logic [3:0]   wr_pulse_o;

   int n_cmp = 0;
   int n_bad = 0;
   logic [31:0] model [4];
   logic [31:0] rd_got;

   always #5 clock = ~clock;

   axi4lite_reg_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(6), .NUM_REGS(4)) dut (
      .clock(clock), .reset(reset),
      .s_axi_awaddr(s_axi_awaddr), .s_axi_awprot(s_axi_awprot),
      .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
      .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
      .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
      .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
      .s_axi_araddr(s_axi_araddr), .s_axi_arprot(s_axi_arprot),
      .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
      .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
      .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
      .regs_o(regs_o), .wr_pulse_o(wr_pulse_o)
   );

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [127:0] model_flat();
      return {model[3], model[2], model[1], model[0]};
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < 4; i++) model[i] = 32'h0;
   endfunction

   // Full write transaction: AW and W raised after independent delays,
   // response held back by BREADY for b_dly cycles.
   task automatic write_txn(input logic [5:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int aw_dly, input int w_dly,
                            input int b_dly);
      int t;
      bit aw_done, w_done, hit;
      int idx;
      logic [1:0] exp_resp;
      logic [3:0] exp_pulse;
      idx       = int'(addr) / 4;
      hit       = idx < 4;
      exp_resp  = hit ? 2'b00 : 2'b10;
      exp_pulse = hit ? 4'(1 << idx) : 4'b0000;
      aw_done = 0; w_done = 0; t = 0;
      s_axi_awaddr = addr; s_axi_wdata = data; s_axi_wstrb = strb;
      while (!(aw_done && w_done) && t < 60) begin
         @(negedge clock);
         s_axi_awvalid = !aw_done && t >= aw_dly;
         s_axi_wvalid  = !w_done && t >= w_dly;
         #1;
         if (s_axi_awvalid && s_axi_awready) aw_done = 1;
         if (s_axi_wvalid && s_axi_wready) w_done = 1;
         t++;
      end
      if (!(aw_done && w_done)) begin
         check_eq("write_accept_timeout", 0, 1);
         s_axi_awvalid = 0; s_axi_wvalid = 0;
         return;
      end
      @(negedge clock);
      s_axi_awvalid = 0; s_axi_wvalid = 0;
      #1;
      if (hit) begin
         for (int b = 0; b < 4; b++)
            if (strb[b]) model[idx][8*b +: 8] = data[8*b +: 8];
      end
      check_eq("bvalid_rise", s_axi_bvalid, 1);
      check_eq("bresp", s_axi_bresp, exp_resp);
      check_eq("wr_pulse", wr_pulse_o, exp_pulse);
      check_eq("regs_after_write", regs_o, model_flat());
      for (int i = 0; i < b_dly; i++) begin
         @(negedge clock); #1;
         check_eq("bvalid_hold", s_axi_bvalid, 1);
         check_eq("bresp_hold", s_axi_bresp, exp_resp);
         check_eq("aw_w_ready_in_resp", {s_axi_awready, s_axi_wready}, 2'b00);
         check_eq("wr_pulse_single", wr_pulse_o, 0);
      end
      @(negedge clock);
      s_axi_bready = 1;
      @(negedge clock);
      s_axi_bready = 0;
      #1;
      check_eq("bvalid_fall", s_axi_bvalid, 0);
      check_eq("aw_w_ready_after_b", {s_axi_awready, s_axi_wready}, 2'b11);
   endtask

   task automatic read_txn(input logic [5:0] addr, input int r_dly, output logic [31:0] got);
      int t;
      bit done, hit;
      int idx;
      logic [31:0] exp_data;
      logic [1:0]  exp_resp;
      idx      = int'(addr) / 4;
      hit      = idx < 4;
      exp_data = hit ? model[idx] : 32'h0;
      exp_resp = hit ? 2'b00 : 2'b10;
      got  = 32'hx;
      done = 0; t = 0;
      s_axi_araddr = addr;
      while (!done && t < 60) begin
         @(negedge clock);
         s_axi_arvalid = 1;
         #1;
         if (s_axi_arready) done = 1;
         t++;
      end
      if (!done) begin
         check_eq("read_accept_timeout", 0, 1);
         s_axi_arvalid = 0;
         return;
      end
      @(negedge clock);
      s_axi_arvalid = 0;
      #1;
      got = s_axi_rdata;
      check_eq("rvalid_rise", s_axi_rvalid, 1);
      check_eq("rdata", s_axi_rdata, exp_data);
      check_eq("rresp", s_axi_rresp, exp_resp);
      for (int i = 0; i < r_dly; i++) begin
         @(negedge clock); #1;
         check_eq("rvalid_hold", s_axi_rvalid, 1);
         check_eq("rdata_hold", s_axi_rdata, exp_data);
         check_eq("arready_in_resp", s_axi_arready, 0);
      end
      @(negedge clock);
      s_axi_rready = 1;
      @(negedge clock);
      s_axi_rready = 0;
      #1;
      check_eq("rvalid_fall", s_axi_rvalid, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1;
      s_axi_awaddr = 0; s_axi_awprot = 0; s_axi_awvalid = 0;
      s_axi_wdata = 0; s_axi_wstrb = 0; s_axi_wvalid = 0; s_axi_bready = 0;
      s_axi_araddr = 0; s_axi_arprot = 0; s_axi_arvalid = 0; s_axi_rready = 0;
      model_reset();

      repeat (3) @(negedge clock);
      #1;
      check_eq("rst_readies", {s_axi_awready, s_axi_wready, s_axi_arready}, 3'b000);
      check_eq("rst_valids", {s_axi_bvalid, s_axi_rvalid}, 2'b00);
      check_eq("rst_resps", {s_axi_bresp, s_axi_rresp}, 4'b0000);
      check_eq("rst_rdata", s_axi_rdata, 0);
      check_eq("rst_regs", regs_o, 0);
      check_eq("rst_pulse", wr_pulse_o, 0);
      @(negedge clock);
      reset = 0;
      #1;
      check_eq("ready_release", {s_axi_awready, s_axi_wready, s_axi_arready}, 3'b111);

      // Sequential write then read-back of all four registers.
      for (int i = 0; i < 4; i++) write_txn(6'(4 * i), 32'(i + 1), 4'hF, 0, 0, 0);
      for (int i = 0; i < 4; i++) begin
         read_txn(6'(4 * i), 0, rd_got);
         check_eq("seq_readback", rd_got, 32'(i + 1));
      end

      // Byte strobes.
      write_txn(6'h04, 32'hAABBCCDD, 4'b1111, 0, 0, 0);
      write_txn(6'h04, 32'h11223344, 4'b0101, 0, 0, 0);
      read_txn(6'h04, 1, rd_got);
      check_eq("strobe_merge", rd_got, 32'hAA22CC44);

      // Decode miss on write and read; low address bits ignored on a hit.
      write_txn(6'h10, 32'hDEADBEEF, 4'hF, 0, 0, 0);
      read_txn(6'h3C, 0, rd_got);
      read_txn(6'h0B, 0, rd_got);

      // Channel ordering and long B stall.
      write_txn(6'h08, 32'h12345678, 4'hF, 5, 0, 0);
      write_txn(6'h0C, 32'h9ABCDEF0, 4'hF, 0, 5, 0);
      write_txn(6'h00, 32'h0F0F0F0F, 4'hF, 0, 0, 10);
      write_txn(6'h04, 32'h55AA55AA, 4'h0, 0, 0, 2);

      // Same-cycle read/write on register 2.
      write_txn(6'h08, 32'h5, 4'hF, 0, 0, 0);
      @(negedge clock);
      s_axi_awaddr = 6'h08; s_axi_wdata = 32'h9; s_axi_wstrb = 4'hF;
      s_axi_araddr = 6'h08;
      s_axi_awvalid = 1; s_axi_wvalid = 1; s_axi_arvalid = 1;
      #1;
      check_eq("samecyc_readies", {s_axi_awready, s_axi_wready, s_axi_arready}, 3'b111);
      @(negedge clock);
      s_axi_awvalid = 0; s_axi_wvalid = 0; s_axi_arvalid = 0;
      #1;
      model[2] = 32'h9;
      check_eq("samecyc_rdata_old", s_axi_rdata, 32'h5);
      check_eq("samecyc_valids", {s_axi_bvalid, s_axi_rvalid}, 2'b11);
      check_eq("samecyc_regs", regs_o, model_flat());
      s_axi_bready = 1; s_axi_rready = 1;
      @(negedge clock);
      s_axi_bready = 0; s_axi_rready = 0;
      read_txn(6'h08, 0, rd_got);
      check_eq("samecyc_rdata_new", rd_got, 32'h9);

      // Reset with only AW captured: the partial write must be discarded.
      @(negedge clock);
      s_axi_awaddr = 6'h00; s_axi_awvalid = 1;
      #1;
      check_eq("partial_aw_ready", s_axi_awready, 1);
      @(negedge clock);
      s_axi_awvalid = 0;
      reset = 1;
      #1;
      check_eq("midrst_readies_low", {s_axi_awready, s_axi_wready, s_axi_arready}, 3'b000);
      @(negedge clock);
      reset = 0;
      model_reset();
      #1;
      check_eq("midrst_readies_high", {s_axi_awready, s_axi_wready, s_axi_arready}, 3'b111);
      check_eq("midrst_bvalid", s_axi_bvalid, 0);
      check_eq("midrst_regs", regs_o, 0);
      write_txn(6'h04, 32'hCAFEF00D, 4'hF, 0, 3, 0);
      read_txn(6'h00, 0, rd_got);

      // Randomized traffic, mostly hits, random strobes and handshake delays.
      for (int i = 0; i < 80; i++) begin
         logic [5:0] a;
         a = ($urandom_range(0, 3) != 0) ? 6'($urandom_range(0, 15)) : 6'($urandom_range(0, 63));
         if ($urandom_range(0, 1) == 0)
            write_txn(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 4),
                      $urandom_range(0, 4), $urandom_range(0, 3));
         else
            read_txn(a, $urandom_range(0, 3), rd_got);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/axi4lite_reg_responder.md
# axi4lite_reg_responder

AXI4-Lite slave (responder) holding four 32-bit read/write control registers. It is the target end of the single-beat AXI4-Lite write/read traffic that our bus-functional master and the PS interconnect issue. It sits behind the interconnect in front of peripheral logic such as the OLEDrgb controller. Register contents and per-register write strobes are exported to that logic.

## Interface
Parameters:
- `DATA_WIDTH`, 32: AXI data width. Only 32 is supported.
- `ADDR_WIDTH`, 6: AXI address width. The byte address space is 0x00–0x3F.
- `NUM_REGS`, 4: number of implemented registers, at word offsets 0x00, 0x04, 0x08 and 0x0C.

Ports:
- `clock`, in, 1: single clock.
- `reset`, in, 1: synchronous, active-high.
- `s_axi_awaddr`, in, ADDR_WIDTH; `s_axi_awprot`, in, 3 (ignored); `s_axi_awvalid`, in, 1; `s_axi_awready`, out, 1.
- `s_axi_wdata`, in, 32; `s_axi_wstrb`, in, 4; `s_axi_wvalid`, in, 1; `s_axi_wready`, out, 1.
- `s_axi_bresp`, out, 2; `s_axi_bvalid`, out, 1; `s_axi_bready`, in, 1.
- `s_axi_araddr`, in, ADDR_WIDTH; `s_axi_arprot`, in, 3 (ignored); `s_axi_arvalid`, in, 1; `s_axi_arready`, out, 1.
- `s_axi_rdata`, out, 32; `s_axi_rresp`, out, 2; `s_axi_rvalid`, out, 1; `s_axi_rready`, in, 1.
- `regs_o`, out, NUM_REGS*32: register contents. Register n occupies bits [32n+31:32n].
- `wr_pulse_o`, out, NUM_REGS: one-cycle pulse in the cycle register n is updated.

## Operation
- **Address decode:** word index = addr[ADDR_WIDTH-1:2]. The low two address bits are ignored. An index below NUM_REGS is a hit; any other index is a miss.
- **Write channel states:** IDLE, HAVE_AW, HAVE_W, RESP.
  - AW and W are accepted independently, in either order or in the same cycle. The address and data/strobe of each are latched at acceptance.
  - Once both are held: in the next cycle, a hit updates the selected byte lanes per `wstrb`, pulses `wr_pulse_o[n]`, sets BVALID and enters RESP.
  - A miss leaves all registers unchanged and responds SLVERR (2'b10). A hit responds OKAY (2'b00).
  - RESP → IDLE on BVALID && BREADY.
- **Write readies:**
  - AWREADY is high only in IDLE and HAVE_W.
  - WREADY is high only in IDLE and HAVE_AW.
  - Neither is asserted while BVALID is high.
  - Only one write is outstanding at a time.
- **Read channel states:** IDLE, RESP.
  - ARREADY is high in IDLE.
  - On AR acceptance, RDATA/RRESP are registered from the current register values and RVALID is set.
  - A hit returns the register value with OKAY. A miss returns 0x00000000 with SLVERR.
  - RDATA/RRESP stay stable until RVALID && RREADY, then return to IDLE.
- **Channel independence:** read and write paths are fully independent.
- **Read/write same register, same cycle:** a read accepted in the same cycle as a write update to that register returns the old value.
- **`wstrb` = 0 on a hit:** OKAY response, no byte changes, `wr_pulse_o` still pulses.

## Timing
- **Reset values (applied while `reset` = 1):**
  - all readies 0, BVALID/RVALID 0;
  - BRESP/RRESP 2'b00, RDATA 0;
  - all registers 0, `wr_pulse_o` 0.
- **Ready release:** readies go high in the first cycle after `reset` falls.
- **Write latency:** with AW and W accepted in cycle k (or the later of the two in cycle k), the register updates and BVALID rises in cycle k+1. The next AW/W can be accepted in the cycle after the B handshake.
- **Read latency:** AR accepted in cycle k → RVALID in cycle k+1. With RREADY held high, one read completes every 2 cycles.
- **BVALID/RVALID hold:** never deasserted before their handshake, even if the master stalls indefinitely.
- **Reset mid-transaction:** reset aborts any partial AW/W capture and any pending response. No register update occurs from an aborted write.

## Structure
- **Shared package `axi4lite_pkg`:**
  - RESP_OKAY = 2'b00 and RESP_SLVERR = 2'b10;
  - the write-state enum (IDLE, HAVE_AW, HAVE_W, RESP);
  - the read-state enum (IDLE, RESP).
- **Single module:** no sub-module. The byte-lane merge is a local function.

## Test plan
- **Sequential write/read:** write 0x1, 0x2, 0x3, 0x4 to 0x00/0x04/0x08/0x0C, then read back → each read returns its written value, all responses OKAY, `wr_pulse_o` shows 0001, 0010, 0100, 1000 in order.
- **Byte strobes:** write 0xAABBCCDD to 0x04 with wstrb 4'b1111, then 0x11223344 with wstrb 4'b0101 → read 0x04 returns 0xAA22CC44.
- **Decode miss:** write 0xDEADBEEF to 0x10 → BRESP SLVERR, no `wr_pulse_o`, registers unchanged. Read 0x3C → RDATA 0x0, RRESP SLVERR.
- **Channel ordering:**
  - W presented 5 cycles before AW, and separately AW/W in the same cycle → both complete OKAY with correct data.
  - BREADY held low for 10 cycles → BVALID and BRESP stay stable and AWREADY/WREADY stay low.
- **Same-cycle read/write:** reg2 = 0x5, then read 0x08 accepted in the update cycle of a write of 0x9 to 0x08 → read returns 0x5, and a subsequent read returns 0x9.
- **Reset mid-operation:** accept AW to 0x00 only, then assert reset for 1 cycle → no BVALID, reg0 = 0. Readies are low during reset and high the cycle after.
